// File: rtl/mdu_div_ctrl.sv
// HI/LO divide controller: sequences an external divider core,
// handles MTHI/MTLO, divide-by-zero bypass and a watchdog abort.
module mdu_div_ctrl #(
    parameter int TIMEOUT = 40
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        op_valid,
    input  logic [1:0]  op,
    input  logic [31:0] rs_val,
    input  logic [31:0] rt_val,
    output logic        op_ready,
    output logic        stall,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        result_valid,
    output logic        timeout_err,
    output logic        div_start,
    output logic        div_signed,
    output logic [31:0] div_dividend,
    output logic [31:0] div_divisor,
    input  logic        div_busy,
    input  logic        div_done,
    input  logic [31:0] div_q,
    input  logic [31:0] div_r
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT
    } state_t;

    localparam logic [5:0] LP_LAST = 6'(TIMEOUT - 1);

    state_t      r_state;
    logic [5:0]  r_cnt;
    logic [31:0] r_hi;
    logic [31:0] r_lo;
    logic [31:0] r_dvd;
    logic [31:0] r_dvs;
    logic        r_signed;
    logic        r_start;
    logic        r_rv;
    logic        r_to;
    logic        w_idle;
    logic        w_is_div;
    logic        w_unused;

    // Core busy is observed only for debug; it never steers the FSM.
    assign w_unused = div_busy;

    assign w_idle   = (r_state == S_IDLE);
    assign w_is_div = ~op[1];

    assign op_ready     = w_idle;
    assign stall        = ~w_idle | (op_valid & w_is_div & w_idle);
    assign hi           = r_hi;
    assign lo           = r_lo;
    assign result_valid = r_rv;
    assign timeout_err  = r_to;
    assign div_start    = r_start;
    assign div_signed   = r_signed;
    assign div_dividend = r_dvd;
    assign div_divisor  = r_dvs;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_hi     <= '0;
            r_lo     <= '0;
            r_dvd    <= '0;
            r_dvs    <= '0;
            r_signed <= 1'b0;
            r_start  <= 1'b0;
            r_rv     <= 1'b0;
            r_to     <= 1'b0;
        end else begin
            r_start <= 1'b0;
            r_rv    <= 1'b0;
            r_to    <= 1'b0;
            unique case (r_state)
                S_IDLE: begin
                    if (op_valid) begin
                        if (op == 2'b10) begin
                            r_hi <= rs_val;
                        end else if (op == 2'b11) begin
                            r_lo <= rs_val;
                        end else if (rt_val == '0) begin
                            // Divide by zero retires at once, HI/LO untouched.
                            r_rv <= 1'b1;
                        end else begin
                            r_dvd    <= rs_val;
                            r_dvs    <= rt_val;
                            r_signed <= ~op[0];
                            r_start  <= 1'b1;
                            r_state  <= S_ISSUE;
                        end
                    end
                end
                S_ISSUE: begin
                    r_cnt   <= '0;
                    r_state <= S_WAIT;
                end
                S_WAIT: begin
                    // A done in the final watchdog cycle still wins.
                    if (div_done) begin
                        r_lo    <= div_q;
                        r_hi    <= div_r;
                        r_rv    <= 1'b1;
                        r_state <= S_IDLE;
                    end else if (r_cnt == LP_LAST) begin
                        r_to    <= 1'b1;
                        r_state <= S_IDLE;
                    end else begin
                        r_cnt <= r_cnt + 6'd1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: doc/mdu_div_ctrl.md
MDU_DIV_CTRL -- requirements
Module: mdu_div_ctrl

Interface
REQ-001 SHALL have parameter TIMEOUT, default 40, meaning the maximum cycles spent in WAIT before abort.
REQ-002 SHALL have port clock  in  1  system clock; all state changes on its rising edge.
REQ-003 SHALL have port reset  in  1  synchronous, active-high reset.
REQ-004 SHALL have port op_valid  in  1  CPU presents an operation.
REQ-005 SHALL have port op  in  2  operation code: 00 DIV (signed), 01 DIVU, 10 MTHI, 11 MTLO.
REQ-006 SHALL have port rs_val  in  32  dividend, or MTHI/MTLO source.
REQ-007 SHALL have port rt_val  in  32  divisor.
REQ-008 SHALL have port op_ready  out  1  controller accepts op this cycle.
REQ-009 SHALL have port stall  out  1  pipeline hold request.
REQ-010 SHALL have port hi  out  32  HI register (remainder).
REQ-011 SHALL have port lo  out  32  LO register (quotient).
REQ-012 SHALL have port result_valid  out  1  one-cycle pulse when a divide operation retires.
REQ-013 SHALL have port timeout_err  out  1  one-cycle pulse on watchdog abort.
REQ-014 SHALL have port div_start  out  1  start strobe to divider core.
REQ-015 SHALL have port div_signed  out  1  selects signed (DIV) versus unsigned (DIVU) core.
REQ-016 SHALL have ports div_dividend, div_divisor  out  32 each  latched operands to core.
REQ-017 SHALL have ports div_busy, div_done  in  1 each  core status.
REQ-018 SHALL have ports div_q, div_r  in  32 each  core quotient and remainder.

Function
REQ-019 SHALL implement the states IDLE, ISSUE and WAIT.
REQ-020 op_ready SHALL be 1 only in IDLE; stall SHALL equal (state!=IDLE) OR (op_valid AND op is 00/01 AND state==IDLE).
REQ-021 IDLE + op_valid + op=10 SHALL write hi<=rs_val at that edge; IDLE + op_valid + op=11 SHALL write lo<=rs_val; state SHALL stay IDLE.
REQ-022 IDLE + op_valid + op in {00,01} + rt_val!=0 SHALL latch div_dividend<=rs_val, div_divisor<=rt_val and div_signed<=~op[0], and go to ISSUE.
REQ-023 IDLE + op_valid + op in {00,01} + rt_val==0 SHALL NOT start the core, SHALL leave hi/lo unchanged, SHALL pulse result_valid next cycle, and SHALL stay IDLE.
REQ-024 ISSUE SHALL assert div_start for exactly one cycle, clear the watchdog counter and go to WAIT.
REQ-025 WAIT + div_done SHALL capture lo<=div_q and hi<=div_r, pulse result_valid next cycle and return to IDLE.
REQ-026 WAIT SHALL increment the 6-bit watchdog counter each cycle without div_done.
REQ-027 When the counter reaches TIMEOUT-1 without div_done, the block SHALL return to IDLE, pulse timeout_err next cycle and leave hi/lo unchanged.
REQ-028 div_done arriving in the same cycle as the timeout SHALL take priority: the result is captured and no error is raised.
REQ-029 op_valid outside IDLE SHALL be ignored (no register write); the CPU holds it under stall.
REQ-030 div_done seen in IDLE or ISSUE SHALL be ignored.
REQ-031 div_busy SHALL be monitoring-only and SHALL NOT affect transitions.

Reset
REQ-032 reset SHALL force the following, overriding all other activity including a divide in flight: state=IDLE, hi=0, lo=0, div_dividend=0, div_divisor=0, div_signed=0, div_start=0, result_valid=0, timeout_err=0, counter=0.
REQ-033 A div_done arriving after a mid-operation reset SHALL NOT modify hi/lo.

Verification
REQ-034 DIV: rs=0xFFFFFFF9 (-7), rt=2, core returns q=0xFFFFFFFD and r=0xFFFFFFFF -> div_start once, div_signed=1, lo=0xFFFFFFFD, hi=0xFFFFFFFF, one result_valid pulse.
REQ-035 DIVU: rs=0xFFFFFFFF, rt=16, core returns q=0x0FFFFFFF and r=0xF -> div_signed=0, lo=0x0FFFFFFF, hi=0x0000000F.
REQ-036 DIV with rt=0 after MTHI 0x1234 and MTLO 0x5678 -> div_start never asserted, hi=0x1234, lo=0x5678, result_valid one cycle later.
REQ-037 DIVU with div_done held low -> timeout_err pulses once 40 cycles into WAIT, state returns to IDLE, hi/lo unchanged; a repeat run with div_done raised in the final cycle -> result captured and no error.
REQ-038 reset asserted mid-WAIT, then a late div_done -> hi=lo=0, op_ready=1, no result_valid.
REQ-039 MTHI 0xAAAA presented while in WAIT -> stall=1, hi unchanged until the CPU re-presents the op in IDLE.
